// File: rtl/ex_stage_md.sv
// EX stage: ALU, branch-target adder, destination mux and EX/MEM register,
// plus an iterative unsigned multiply/divide unit with HI/LO registers.
// Handshake: Flush kills, MEM_Stall holds, and the stage interlocks
// MULTU/DIVU/MFHI/MFLO against a multiply/divide that is still running.
module ex_stage_md #(
   parameter int WIDTH = 32,
   parameter int AW    = 5,
   parameter int SW    = 5
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             In_Valid,
   input  logic [1:0]       WB_IN,
   input  logic [2:0]       MEM_IN,
   input  logic [3:0]       ALUCtl,
   input  logic             ALUSrc,
   input  logic             RegDst,
   input  logic [WIDTH-1:0] RD1,
   input  logic [WIDTH-1:0] RD2,
   input  logic [WIDTH-1:0] Imm,
   input  logic [WIDTH-1:0] PC4,
   input  logic [SW-1:0]    Shamt,
   input  logic [AW-1:0]    Rt,
   input  logic [AW-1:0]    Rd,
   input  logic             Flush,
   input  logic             MEM_Stall,
   output logic             Stall_OUT,
   output logic             MD_Busy_OUT,
   output logic             Valid_OUT,
   output logic [1:0]       WB_OUT,
   output logic [2:0]       MEM_OUT,
   output logic [WIDTH-1:0] BranchPC_OUT,
   output logic             Zero_OUT,
   output logic [WIDTH-1:0] AluResult_OUT,
   output logic [WIDTH-1:0] RD2_OUT,
   output logic [AW-1:0]    WR_OUT
);

   // Counter must hold the value WIDTH itself, hence one extra bit.
   localparam int CW = SW + 1;

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_OR    = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_XOR   = 4'b0011;
   localparam logic [3:0] OP_NOR   = 4'b0100;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_SLT   = 4'b0111;
   localparam logic [3:0] OP_SLTU  = 4'b1000;
   localparam logic [3:0] OP_SLL   = 4'b1001;
   localparam logic [3:0] OP_SRL   = 4'b1010;
   localparam logic [3:0] OP_SRA   = 4'b1011;
   localparam logic [3:0] OP_MULTU = 4'b1100;
   localparam logic [3:0] OP_DIVU  = 4'b1101;
   localparam logic [3:0] OP_MFHI  = 4'b1110;
   localparam logic [3:0] OP_MFLO  = 4'b1111;

   // EX/MEM pipeline register
   logic             valid_q, valid_d;
   logic [1:0]       wb_q, wb_d;
   logic [2:0]       mem_q, mem_d;
   logic [WIDTH-1:0] bpc_q, bpc_d;
   logic             zero_q, zero_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] rd2_q, rd2_d;
   logic [AW-1:0]    wr_q, wr_d;

   // Multiply/divide state: acc holds the running HI (product high half or
   // partial remainder), lo_w the running LO (multiplier or quotient).
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] lo_w_q, lo_w_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic             is_div_q, is_div_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;

   logic [WIDTH-1:0] b_op;
   logic [WIDTH-1:0] alu_res;
   logic             is_md, is_mf, md_busy, interlock, md_start;

   assign b_op      = ALUSrc ? Imm : RD2;
   assign is_md     = (ALUCtl == OP_MULTU) || (ALUCtl == OP_DIVU);
   assign is_mf     = (ALUCtl == OP_MFHI) || (ALUCtl == OP_MFLO);
   assign md_busy   = (cnt_q != '0);
   assign interlock = In_Valid && (is_md || is_mf) && md_busy;

   // ALU result for the instruction currently presented by ID/EX
   always_comb begin
      alu_res = '0;
      case (ALUCtl)
         OP_AND:  alu_res = RD1 & b_op;
         OP_OR:   alu_res = RD1 | b_op;
         OP_ADD:  alu_res = RD1 + b_op;
         OP_XOR:  alu_res = RD1 ^ b_op;
         OP_NOR:  alu_res = ~(RD1 | b_op);
         OP_SUB:  alu_res = RD1 - b_op;
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(RD1) < $signed(b_op))};
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (RD1 < b_op)};
         OP_SLL:  alu_res = b_op << Shamt;
         OP_SRL:  alu_res = b_op >> Shamt;
         OP_SRA:  alu_res = $unsigned($signed(b_op) >>> Shamt);
         OP_MFHI: alu_res = hi_q;
         OP_MFLO: alu_res = lo_q;
         default: alu_res = '0;   // MULTU, DIVU and the unused 0101
      endcase
   end

   // EX/MEM update priority: flush, downstream stall, interlock, accept
   always_comb begin
      valid_d   = valid_q;
      wb_d      = wb_q;
      mem_d     = mem_q;
      bpc_d     = bpc_q;
      zero_d    = zero_q;
      res_d     = res_q;
      rd2_d     = rd2_q;
      wr_d      = wr_q;
      Stall_OUT = 1'b0;
      md_start  = 1'b0;
      if (Flush || (!MEM_Stall && (interlock || !In_Valid))) begin
         // Bubble: every field cleared so its contents are deterministic.
         valid_d   = 1'b0;
         wb_d      = '0;
         mem_d     = '0;
         bpc_d     = '0;
         zero_d    = 1'b0;
         res_d     = '0;
         rd2_d     = '0;
         wr_d      = '0;
         Stall_OUT = !Flush && interlock;
      end else if (MEM_Stall) begin
         Stall_OUT = 1'b1;
      end else begin
         valid_d  = 1'b1;
         wb_d     = WB_IN;
         mem_d    = MEM_IN;
         bpc_d    = PC4 + {Imm[WIDTH-3:0], 2'b00};
         zero_d   = (alu_res == '0);
         res_d    = alu_res;
         rd2_d    = RD2;
         wr_d     = RegDst ? Rd : Rt;
         md_start = is_md;
      end
   end

   // One radix-2 multiply/divide step per cycle; HI/LO written on the last
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH-1:0] div_diff;
   logic             div_ge;

   always_comb begin
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      lo_w_d   = lo_w_q;
      opnd_d   = opnd_q;
      is_div_d = is_div_q;
      hi_d     = hi_q;
      lo_d     = lo_q;

      // Shift-add: conditionally add the multiplicand, then shift right.
      mul_sum   = {1'b0, acc_q} + (lo_w_q[0] ? {1'b0, opnd_q} : '0);
      // Restoring divide: shift left, subtract divisor if it fits.
      div_shift = {acc_q, lo_w_q[WIDTH-1]};
      div_ge    = (div_shift >= {1'b0, opnd_q});
      div_diff  = div_shift[WIDTH-1:0] - opnd_q;

      if (md_busy) begin
         if (is_div_q) begin
            acc_d  = div_ge ? div_diff : div_shift[WIDTH-1:0];
            lo_w_d = {lo_w_q[WIDTH-2:0], div_ge};
         end else begin
            acc_d  = mul_sum[WIDTH:1];
            lo_w_d = {mul_sum[0], lo_w_q[WIDTH-1:1]};
         end
         cnt_d = cnt_q - 1'b1;
         if (cnt_q == CW'(1)) begin
            hi_d = acc_d;
            lo_d = lo_w_d;
         end
      end else if (md_start) begin
         cnt_d    = CW'(WIDTH);
         acc_d    = '0;
         lo_w_d   = RD1;
         opnd_d   = b_op;
         is_div_d = (ALUCtl == OP_DIVU);
      end
   end

   // State registers, cleared asynchronously by Rst_n
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         valid_q  <= 1'b0;
         wb_q     <= '0;
         mem_q    <= '0;
         bpc_q    <= '0;
         zero_q   <= 1'b0;
         res_q    <= '0;
         rd2_q    <= '0;
         wr_q     <= '0;
         cnt_q    <= '0;
         acc_q    <= '0;
         lo_w_q   <= '0;
         opnd_q   <= '0;
         is_div_q <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         valid_q  <= valid_d;
         wb_q     <= wb_d;
         mem_q    <= mem_d;
         bpc_q    <= bpc_d;
         zero_q   <= zero_d;
         res_q    <= res_d;
         rd2_q    <= rd2_d;
         wr_q     <= wr_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         lo_w_q   <= lo_w_d;
         opnd_q   <= opnd_d;
         is_div_q <= is_div_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   assign MD_Busy_OUT   = md_busy;
   assign Valid_OUT     = valid_q;
   assign WB_OUT        = wb_q;
   assign MEM_OUT       = mem_q;
   assign BranchPC_OUT  = bpc_q;
   assign Zero_OUT      = zero_q;
   assign AluResult_OUT = res_q;
   assign RD2_OUT       = rd2_q;
   assign WR_OUT        = wr_q;

endmodule
